// File: rtl/video_timing_gen_pkg.sv
// Shared definitions for the video timing generator: pattern codes,
// FSM state encoding, default raster timing and the color-bar table.
package video_timing_gen_pkg;

    // Default raster: 640x480 active inside an 800x525 total.
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_START  = 144;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_V_START  = 35;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_BAR_W    = 80;

    typedef enum logic [1:0] {
        PAT_GRAY    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_BARS    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    localparam logic [7:0] GRAY_LEVEL   = 8'h80;
    // Checker squares are 16 pixels/lines wide: select bit 4 of x^y.
    localparam logic [7:0] CHECKER_MASK = 8'h10;

    // Eight-bar RGB table, left to right.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] color;
        case (idx)
            3'd0:    color = 24'hFFFFFF; // white
            3'd1:    color = 24'hFFFF00; // yellow
            3'd2:    color = 24'h00FFFF; // cyan
            3'd3:    color = 24'h00FF00; // green
            3'd4:    color = 24'hFF00FF; // magenta
            3'd5:    color = 24'hFF0000; // red
            3'd6:    color = 24'h0000FF; // blue
            default: color = 24'h000000; // black
        endcase
        return color;
    endfunction

endpackage

// File: rtl/video_timing_gen_pattern.sv
// Test-pattern pixel generator: one registered RGB word per pixel.
// Optional macro VTG_FRAME_CNT_EN adds a per-frame offset to the ramp.
module vtg_pattern
    import video_timing_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  pattern_e    pattern,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  bar_idx,
    input  logic        active,
`ifdef VTG_FRAME_CNT_EN
    input  logic [7:0]  ramp_ofs,
`endif
    output logic [23:0] rgb
);

    logic [7:0] ramp_val;

`ifdef VTG_FRAME_CNT_EN
    assign ramp_val = x + ramp_ofs;
`else
    assign ramp_val = x;
`endif

    // Pixel register: black outside the active region, pattern inside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= '0;
        end else if (!active) begin
            rgb <= '0;
        end else begin
            case (pattern)
                PAT_GRAY: rgb <= {3{GRAY_LEVEL}};
                PAT_RAMP: rgb <= {3{ramp_val}};
                PAT_BARS: rgb <= bar_rgb(bar_idx);
                default:  rgb <= (((x ^ y) & CHECKER_MASK) != 8'h00) ? 24'h000000 : 24'hFFFFFF;
            endcase
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source with test pattern fill (vs/hs/de + 3x8-bit RGB).
// Optional macro VTG_FRAME_CNT_EN adds the frame_cnt output and ramp offset.
// All outputs are registered from the next counter state, so the first RUN
// cycle (h_cnt = 0, v_cnt = 0) already shows hs_out high.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_START  = DEF_H_START,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_START  = DEF_V_START,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int BAR_W    = DEF_BAR_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic        vs_out,
    output logic        hs_out,
    output logic        de_out,
`ifdef VTG_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic [7:0]  data1_out,
    output logic [7:0]  data2_out,
    output logic [7:0]  data3_out
);

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] H_ACT_BEG = 12'(H_START);
    localparam logic [11:0] H_ACT_END = 12'(H_START + H_ACTIVE);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_ACT_BEG = 12'(V_START);
    localparam logic [11:0] V_ACT_END = 12'(V_START + V_ACTIVE);
    localparam logic [11:0] BAR_LAST  = 12'(BAR_W - 1);
    localparam logic [7:0]  X_ORIGIN  = 8'(H_START);
    localparam logic [7:0]  Y_ORIGIN  = 8'(V_START);

    state_e      state_reg, state_next;
    logic [11:0] h_cnt_reg, h_next, h_adv;
    logic [11:0] v_cnt_reg, v_next, v_adv;
    pattern_e    pat_reg, pat_next;
    logic [11:0] bar_px_reg, bar_px_next;
    logic [2:0]  bar_idx_reg, bar_idx_next;
    logic        at_last;
    logic        running_next;
    logic        h_in, v_in;
    logic        hs_next, vs_next, de_next;
    logic [7:0]  x_next, y_next;
    logic [23:0] rgb;

    // FSM transition and counter advance for the coming cycle.
    always_comb begin
        at_last = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);
        h_adv   = (h_cnt_reg == H_LAST) ? 12'd0 : h_cnt_reg + 12'd1;
        v_adv   = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            v_adv = (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
        end
        state_next = state_reg;
        h_next     = h_adv;
        v_next     = v_adv;
        case (state_reg)
            ST_IDLE: begin
                h_next = 12'd0;
                v_next = 12'd0;
                if (en) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_next = ST_STOPPING;
            end
            ST_STOPPING: begin
                // A returning en resumes the current frame; otherwise finish it.
                if (en) begin
                    state_next = ST_RUN;
                end else if (at_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                h_next     = 12'd0;
                v_next     = 12'd0;
            end
        endcase
    end

    // Region decode, pattern latch and bar tracking for the coming pixel.
    always_comb begin
        running_next = (state_next != ST_IDLE);
        h_in    = (h_next >= H_ACT_BEG) && (h_next < H_ACT_END);
        v_in    = (v_next >= V_ACT_BEG) && (v_next < V_ACT_END);
        hs_next = running_next && (h_next < H_SYNC_END);
        vs_next = running_next && v_in;
        de_next = running_next && v_in && h_in;
        x_next  = h_next[7:0] - X_ORIGIN;
        y_next  = v_next[7:0] - Y_ORIGIN;

        // Pattern changes only take effect at a frame boundary.
        pat_next = pat_reg;
        if (running_next && (h_next == 12'd0) && (v_next == 12'd0)) begin
            pat_next = pattern_e'(pattern_sel);
        end

        bar_px_next  = bar_px_reg;
        bar_idx_next = bar_idx_reg;
        if (h_next == H_ACT_BEG) begin
            bar_px_next  = 12'd0;
            bar_idx_next = 3'd0;
        end else if (h_in) begin
            if (bar_px_reg == BAR_LAST) begin
                bar_px_next = 12'd0;
                if (bar_idx_reg != 3'd7) bar_idx_next = bar_idx_reg + 3'd1;
            end else begin
                bar_px_next = bar_px_reg + 12'd1;
            end
        end
    end

    // State, counters and the latched pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            pat_reg     <= PAT_GRAY;
            bar_px_reg  <= '0;
            bar_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            h_cnt_reg   <= h_next;
            v_cnt_reg   <= v_next;
            pat_reg     <= pat_next;
            bar_px_reg  <= bar_px_next;
            bar_idx_reg <= bar_idx_next;
        end
    end

    // Sync outputs, registered alongside the pixel data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            de_out <= 1'b0;
        end else begin
            hs_out <= hs_next;
            vs_out <= vs_next;
            de_out <= de_next;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg, frame_cnt_next;

    assign frame_cnt_next = ((state_reg != ST_IDLE) && at_last) ? frame_cnt_reg + 16'd1
                                                                : frame_cnt_reg;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_cnt_reg <= '0;
        else     frame_cnt_reg <= frame_cnt_next;
    end

    assign frame_cnt = frame_cnt_reg;
`endif

    vtg_pattern u_pattern (
        .clk      (clk),
        .rst      (rst),
        .pattern  (pat_next),
        .x        (x_next),
        .y        (y_next),
        .bar_idx  (bar_idx_next),
        .active   (de_next),
`ifdef VTG_FRAME_CNT_EN
        .ramp_ofs (frame_cnt_next[7:0]),
`endif
        .rgb      (rgb)
    );

    assign data1_out = rgb[23:16];
    assign data2_out = rgb[15:8];
    assign data3_out = rgb[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small 16x8 raster.
module tb_video_timing_gen;

    localparam int HT = 16, HSY = 2, HST = 4, HA = 8;
    localparam int VT = 8, VST = 2, VA = 4, BW = 1;
    localparam int FRAME = HT * VT;
`ifdef VTG_FRAME_CNT_EN
    localparam int RAMP_F2 = 2;
`else
    localparam int RAMP_F2 = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       vs_out, hs_out, de_out;
    logic [7:0] data1_out, data2_out, data3_out;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_TOTAL(HT), .H_SYNC(HSY), .H_START(HST), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .BAR_W(BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .vs_out      (vs_out),
        .hs_out      (hs_out),
        .de_out      (de_out),
`ifdef VTG_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .data1_out   (data1_out),
        .data2_out   (data2_out),
        .data3_out   (data3_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Reference: expected {vs,hs,de,rgb} from frame position and pattern.
    function automatic logic [26:0] model_out(int st, int pos, int pat, int fc);
        int h, v, x, y, bi;
        logic hs, vs, de;
        logic [7:0] r;
        logic [23:0] rgb;
        if (st == 0) return 27'd0;
        h  = pos % HT;
        v  = pos / HT;
        hs = (h < HSY);
        vs = (v >= VST) && (v < VST + VA);
        de = vs && (h >= HST) && (h < HST + HA);
        x  = h - HST;
        y  = v - VST;
        rgb = 24'd0;
        if (de) begin
            case (pat)
                0: rgb = 24'h808080;
                1: begin r = 8'((x + fc) % 256); rgb = {r, r, r}; end
                2: begin bi = x / BW; if (bi > 7) bi = 7; rgb = bar_tab[bi]; end
                default: rgb = (((x / 16) % 2) != ((y / 16) % 2)) ? 24'h000000 : 24'hFFFFFF;
            endcase
        end
        return {vs, hs, de, rgb};
    endfunction

    // Model state: 0 idle, 1 run, 2 stopping.
    int m_st = 0, m_pos = 0, m_pat = 0, m_fc = 0;
    bit m_last;
    logic [26:0] exp_q [$];
    logic [15:0] fc_q [$];
    logic [26:0] e_sig;
    logic [15:0] e_fc;

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_pos = 0; m_pat = 0; m_fc = 0;
        end else if (m_st == 0) begin
            if (en) begin m_st = 1; m_pos = 0; m_pat = int'(pattern_sel); end
        end else begin
            m_last = (m_pos == FRAME - 1);
            if (m_last) m_fc = (m_fc + 1) % 65536;
            if (m_st == 1) m_st = en ? 1 : 2;
            else           m_st = en ? 1 : (m_last ? 0 : 2);
            m_pos = (m_st == 0) ? 0 : (m_pos + 1) % FRAME;
            if (m_st != 0 && m_pos == 0) m_pat = int'(pattern_sel);
        end
`ifdef VTG_FRAME_CNT_EN
        exp_q.push_back(model_out(m_st, m_pos, m_pat, m_fc));
`else
        exp_q.push_back(model_out(m_st, m_pos, m_pat, 0));
`endif
        fc_q.push_back(16'(m_fc));
    end

    // Monitor: compare every cycle against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_sig = exp_q.pop_front();
            e_fc  = fc_q.pop_front();
            if (!rst) begin
                check_val("stream", 32'({vs_out, hs_out, de_out, data1_out, data2_out, data3_out}),
                          32'(e_sig));
`ifdef VTG_FRAME_CNT_EN
                check_val("frame_cnt", 32'(frame_cnt), 32'(e_fc));
`endif
            end
        end
    end

    initial begin
        int de_cyc, hs_cyc, vs_cyc, de_rise, first_vs, first_de, k, nz;
        logic prev_de;

        repeat (3) @(negedge clk);
        check_val("reset_outputs", 32'({vs_out, hs_out, de_out, data1_out, data2_out, data3_out}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Frame 0: timing, gray.
        en = 1'b1; pattern_sel = 2'd0;
        de_cyc = 0; hs_cyc = 0; vs_cyc = 0; de_rise = 0; first_vs = -1; first_de = -1; prev_de = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) check_val("hs_first_run", 32'(hs_out), 32'd1);
            if (de_out) de_cyc++;
            if (hs_out) hs_cyc++;
            if (vs_out) vs_cyc++;
            if (de_out && !prev_de) de_rise++;
            prev_de = de_out;
            if (vs_out && first_vs < 0) first_vs = i;
            if (de_out && first_de < 0) first_de = i;
        end
        check_val("de_cycles", de_cyc, 32);
        check_val("de_pulses", de_rise, 4);
        check_val("hs_cycles", hs_cyc, 16);
        check_val("vs_cycles", vs_cyc, 64);
        check_val("vs_lead_de", first_de - first_vs, 4);
        $display("frame0 timing: de=%0d pulses=%0d hs=%0d vs=%0d", de_cyc, de_rise, hs_cyc, vs_cyc);

        // Frame 1: color bars.
        pattern_sel = 2'd2; k = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (de_out) begin
                check_val("bar_px", 32'({data1_out, data2_out, data3_out}), 32'(bar_tab[k % 8]));
                k++;
            end
        end
        check_val("bar_px_count", k, 32);
        $display("frame1 bars: %0d pixels", k);

        // Frame 2: ramp, selection changes to checker mid-frame.
        pattern_sel = 2'd1; k = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (de_out) begin
                check_val("ramp_px", 32'({data1_out, data2_out, data3_out}),
                          32'({3{8'((k % 8 + RAMP_F2) % 256)}}));
                k++;
            end
            if (i == 40) pattern_sel = 2'd3;
        end
        $display("frame2 ramp: %0d pixels", k);

        // Frame 3: checker, en dropped on line 3.
        de_cyc = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
`ifdef VTG_FRAME_CNT_EN
            if (i == 0) check_val("frame_cnt_3", 32'(frame_cnt), 32'd3);
`endif
            if (de_out) begin
                check_val("checker_px", 32'({data1_out, data2_out, data3_out}), 32'hFFFFFF);
                de_cyc++;
            end
            if (i == 48) en = 1'b0;
        end
        check_val("stop_frame_de", de_cyc, 32);

        hs_cyc = 0; nz = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hs_out) hs_cyc++;
            if ({vs_out, hs_out, de_out, data1_out, data2_out, data3_out} != 27'd0) nz++;
        end
        check_val("idle_hs", hs_cyc, 0);
        check_val("idle_nonzero", nz, 0);
`ifdef VTG_FRAME_CNT_EN
        check_val("frame_cnt_held", 32'(frame_cnt), 32'd4);
`endif
        $display("stop: frame completed with de=%0d, idle hs=%0d", de_cyc, hs_cyc);

        // Restart after stop, then async reset mid-line.
        en = 1'b1; pattern_sel = 2'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0)  check_val("restart_hs", 32'(hs_out), 32'd1);
            if (i == 31) check_val("restart_vs_low", 32'(vs_out), 32'd0);
            if (i == 32) check_val("restart_vs_rise", 32'(vs_out), 32'd1);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_val("rst_async", 32'({vs_out, hs_out, de_out, data1_out, data2_out, data3_out}), 32'd0);
`ifdef VTG_FRAME_CNT_EN
        check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) check_val("post_rst_hs", 32'(hs_out), 32'd1);
            if (i == 0) check_val("post_rst_vs", 32'(vs_out), 32'd0);
            if (i == 32) check_val("post_rst_vs_rise", 32'(vs_out), 32'd1);
        end
        $display("reset: restart from line 0 observed");
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Source end of the vs/hs/de + three-channel 8-bit pixel stream that the image-processing blocks consume. It generates raster timing from programmable counters and fills the active region with a selectable test pattern. It sits at the head of the image-processing pipeline in simulation and FPGA bring-up, in place of a camera or decoder, and drives downstream blocks such as region blanking and filters directly.

## Interface
- H_TOTAL, 800: clocks per line.
- H_SYNC, 96: hs pulse width in clocks, from h_cnt 0.
- H_START, 144: h_cnt of first active pixel; H_START >= 1.
- H_ACTIVE, 640: active pixels per line; H_START+H_ACTIVE < H_TOTAL.
- V_TOTAL, 525: lines per frame.
- V_START, 35: v_cnt of first active line.
- V_ACTIVE, 480: active lines; V_START+V_ACTIVE <= V_TOTAL.
- BAR_W, 80: color-bar width in pixels; BAR_W >= 1.
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request.
- pattern_sel  in  2  0 solid gray 0x80, 1 horizontal ramp, 2 color bars, 3 checkerboard.
- vs_out  out  1  high for all clocks of lines v_cnt in [V_START, V_START+V_ACTIVE).
- hs_out  out  1  high for h_cnt in [0, H_SYNC), on every line.
- de_out  out  1  high when vs region AND h_cnt in [H_START, H_START+H_ACTIVE).
- data1_out / data2_out / data3_out  out  8 each  R / G / B. Value is 0 whenever de_out = 0.

## Operation
- States:
  - IDLE: counters at 0, all outputs 0.
  - RUN: counters advance.
  - STOPPING: RUN until end of frame.
- Transitions:
  - IDLE -> RUN when en = 1 is sampled. h_cnt = 0, v_cnt = 0 on the first RUN cycle.
  - RUN -> STOPPING when en = 0.
  - STOPPING -> RUN when en = 1 returns before the frame ends. No restart occurs.
  - STOPPING -> IDLE on the last clock of the frame (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1).
- Counters:
  - h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt.
  - v_cnt wraps V_TOTAL-1 -> 0.
  - Both are 12 bits.
- pattern_sel is latched only at h_cnt = 0, v_cnt = 0, and on entering RUN. A change mid-frame has no effect until the next frame.
- Pixel coordinates:
  - x = h_cnt - H_START and y = v_cnt - V_START, meaningful only in the active region.
  - The bar index is a counter cleared at each line's first active pixel. It increments every BAR_W pixels and saturates at 7.
- Patterns:
  - Ramp: all channels = x[7:0], wrapping every 256 pixels.
  - Bars, indices 0..7: white FF/FF/FF, yellow FF/FF/00, cyan 00/FF/FF, green 00/FF/00, magenta FF/00/FF, red FF/00/00, blue 00/00/FF, black 00/00/00.
  - Checker: x[4]^y[4] = 0 gives FF on all channels, otherwise 00.
- Reset asserted at any time: outputs 0 immediately (asynchronous), state IDLE, counters 0.

## Timing
- All outputs are registered from the same counter state, so vs/hs/de/data are mutually aligned with no skew.
- First RUN cycle (h_cnt = 0, v_cnt = 0):
  - hs_out = 1 on the clock after en is first sampled high.
  - vs_out = 0 unless V_START = 0.
- vs_out rises at h_cnt = 0 of line V_START.
  - de_out first rises H_START clocks later (H_START >= 1 guarantees vs leads de).
  - de_out falls at least one clock before each line end.
- de_out pulse: exactly H_ACTIVE clocks per active line. de_out is 0 for at least one clock between lines.
- Frame period: H_TOTAL*V_TOTAL clocks. Back-to-back frames have no gap while en = 1.

## Configuration
- VTG_FRAME_CNT_EN:
  - Defined: adds output frame_cnt[15:0].
    - Reset 0.
    - Increments on the last clock of every completed frame.
    - Wraps 0xFFFF -> 0.
    - Held in IDLE.
    - Ramp pattern becomes x[7:0] + frame_cnt[7:0], mod 256.
  - Undefined: no port, no counter, ramp = x[7:0].

## Structure
- Shared package: pattern_sel codes, the 8-entry color-bar RGB table, and default timing constants.
- One sub-module: vtg_pattern.
  - Inputs: latched pattern_sel, x, y, bar index, active flag.
  - Output: registered RGB.
  - The top-level keeps the FSM, counters, and sync generation.

## Test plan
Bench parameters: H_TOTAL=16, H_SYNC=2, H_START=4, H_ACTIVE=8, V_TOTAL=8, V_START=2, V_ACTIVE=4, BAR_W=1.

- Timing: en = 1, pattern 0.
  - Required: 4 de pulses of 8 clocks per 128-clock frame.
  - hs high 2 clocks per line.
  - vs high 64 clocks, rising 4 clocks before the first de.
  - data 80/80/80 during de, 0 otherwise.
- Bars: pattern 2.
  - Pixels 0..7 of each line are the exact table sequence FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Stop: en dropped at line 3 of frame 1.
  - Required: frame 1 completes all 4 active lines, then outputs 0 and no further hs.
  - Re-asserting en restarts at h_cnt = 0.
- Mid-frame select: pattern_sel 1 -> 3 during frame 0.
  - Required: frame 0 stays a ramp 00..07.
  - Frame 1 is a checker; all FF for this 8x4 size, since x[4] = y[4] = 0.
- Reset: rst pulsed mid-line.
  - Required: all outputs 0 in the same cycle.
  - After release with en = 1, the frame restarts from v_cnt = 0.
- With VTG_FRAME_CNT_EN: run 3 frames.
  - Required: frame_cnt = 3.
  - Ramp on frame 2 starts at 02.
